// File: rtl/sli_video_source.sv
// sli_video_source: internal RGB test-pattern transmitter with hsync/vsync/blank.
// Produces the same timing stream the SLI pixel pipeline expects from the HDMI
// input. Also reports frame-start and a count of completed frames.
module sli_video_source #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [1:0] pat_sel,
    input  logic [7:0] level,
    output logic [7:0] out_red,
    output logic [7:0] out_green,
    output logic [7:0] out_blue,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_blank,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    pat_q, pat_d;
    logic [7:0]    lvl_q, lvl_d;

    logic [7:0]    red_q, red_d;
    logic [7:0]    green_q, green_d;
    logic [7:0]    blue_q, blue_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic          fstart_q, fstart_d;
    logic [7:0]    fcnt_q, fcnt_d;

    logic          h_last;
    logic          v_last;
    logic          frame_end;
    logic          active;
    logic [15:0]   x16;
    logic [15:0]   y16;
    logic [23:0]   pix;

    assign h_last    = (h_q == H_LAST);
    assign v_last    = (v_q == V_LAST);
    assign frame_end = h_last && v_last;
    assign active    = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign x16       = 16'(h_q);
    assign y16       = 16'(v_q);

    // Run/idle control, raster counters, bar tracking and frame-boundary latching of pattern settings.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        lvl_d     = lvl_q;
        case (state_q)
            IDLE: begin
                h_d       = '0;
                v_d       = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
                if (en) begin
                    state_d = RUN;
                    pat_d   = pat_sel;
                    lvl_d   = level;
                end
            end
            RUN: begin
                if (h_last) begin
                    h_d       = '0;
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                    v_d       = v_last ? '0 : v_q + VW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                    if (bar_cnt_q == BAR_LAST) begin
                        bar_cnt_d = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + BW'(1);
                    end
                end
                if (frame_end) begin
                    if (en) begin
                        pat_d = pat_sel;
                        lvl_d = level;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel colour for the current raster position under the latched pattern.
    always_comb begin
        pix = 24'h000000;
        case (pat_q)
            2'd0: pix = {lvl_q, lvl_q, lvl_q};
            2'd1: pix = {x16[7:0], x16[7:0], x16[7:0]};
            2'd2: begin
                case (bar_idx_q)
                    3'd0: pix = 24'hFFFFFF;
                    3'd1: pix = 24'hFFFF00;
                    3'd2: pix = 24'h00FFFF;
                    3'd3: pix = 24'h00FF00;
                    3'd4: pix = 24'hFF00FF;
                    3'd5: pix = 24'hFF0000;
                    3'd6: pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            default: pix = (x16[5] ^ y16[5]) ? {lvl_q, lvl_q, lvl_q} : 24'h000000;
        endcase
    end

    // Output stage: one clock behind the counters; idle shows the reset-state stream.
    always_comb begin
        red_d    = 8'h00;
        green_d  = 8'h00;
        blue_d   = 8'h00;
        hsync_d  = 1'b0;
        vsync_d  = 1'b0;
        blank_d  = 1'b1;
        fstart_d = 1'b0;
        fcnt_d   = fcnt_q;
        if (state_q == RUN) begin
            if (active) begin
                red_d   = pix[23:16];
                green_d = pix[15:8];
                blue_d  = pix[7:0];
            end
            hsync_d  = (h_q >= HS_START) && (h_q < HS_END);
            vsync_d  = (v_q >= VS_START) && (v_q < VS_END);
            blank_d  = !active;
            fstart_d = (h_q == '0) && (v_q == '0);
            if (frame_end) begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            h_q       <= '0;
            v_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            lvl_q     <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            blank_q   <= 1'b1;
            fstart_q  <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            lvl_q     <= lvl_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_q   <= blank_d;
            fstart_q  <= fstart_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign out_red     = red_q;
    assign out_green   = green_q;
    assign out_blue    = blue_q;
    assign out_hsync   = hsync_q;
    assign out_vsync   = vsync_q;
    assign out_blank   = blank_q;
    assign frame_start = fstart_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_sli_video_source.sv
// Bench for sli_video_source using the small timing build (24 x 8 raster).
// Table of pattern vectors, hand-written timing and corner sequences, and a
// randomized run compared against a frame-position reference model.
module tb_sli_video_source;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    localparam logic [35:0] RESET_VEC = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

    logic       clk;
    logic       rstn;
    logic       en;
    logic [1:0] pat_sel;
    logic [7:0] level;
    logic [7:0] out_red, out_green, out_blue;
    logic       out_hsync, out_vsync, out_blank;
    logic       frame_start;
    logic [7:0] frame_cnt;
    logic [35:0] dutVec;

    int checks;
    int errors;

    sli_video_source #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .pat_sel(pat_sel),
        .level(level),
        .out_red(out_red),
        .out_green(out_green),
        .out_blue(out_blue),
        .out_hsync(out_hsync),
        .out_vsync(out_vsync),
        .out_blank(out_blank),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    assign dutVec = {out_red, out_green, out_blue, out_hsync, out_vsync, out_blank, frame_start, frame_cnt};

    // Free-running pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a frame is a linear sequence of FRAME positions.
    bit          mRun;
    int          mPos;
    int          mFrames;
    logic [1:0]  mPat;
    logic [7:0]  mLvl;
    logic [35:0] expVec;

    function automatic logic [23:0] barColour(input int idx);
        logic [23:0] table8 [8];
        table8 = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return table8[idx];
    endfunction

    function automatic logic [35:0] expectedAt(input int pos, input logic [1:0] pat,
                                               input logic [7:0] lvl, input int frames);
        int x, y;
        bit act, hs, vs;
        logic [23:0] rgb;
        x = pos % HT;
        y = pos / HT;
        act = (x < HA) && (y < VA);
        hs = (x >= HA + HFP) && (x < HA + HFP + HS);
        vs = (y >= VA + VFP) && (y < VA + VFP + VS);
        rgb = 24'h0;
        if (act) begin
            case (pat)
                2'd0: rgb = {lvl, lvl, lvl};
                2'd1: rgb = {3{8'(x % 256)}};
                2'd2: rgb = barColour(x / (HA / 8));
                default: rgb = ((((x >> 5) & 1) ^ ((y >> 5) & 1)) != 0) ? {lvl, lvl, lvl} : 24'h0;
            endcase
        end
        return {rgb, hs, vs, !act, (pos == 0), 8'(frames % 256)};
    endfunction

    task automatic modelReset();
        mRun = 0;
        mPos = 0;
        mFrames = 0;
        mPat = 2'd0;
        mLvl = 8'd0;
        expVec = RESET_VEC;
    endtask

    task automatic modelStep(input logic e, input logic [1:0] p, input logic [7:0] l);
        if (!mRun) begin
            expVec = {24'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(mFrames % 256)};
            if (e) begin
                mRun = 1;
                mPos = 0;
                mPat = p;
                mLvl = l;
            end
        end else begin
            if (mPos == FRAME - 1) mFrames++;
            expVec = expectedAt(mPos, mPat, mLvl, mFrames);
            if (mPos == FRAME - 1) begin
                if (e) begin
                    mPos = 0;
                    mPat = p;
                    mLvl = l;
                end else begin
                    mRun = 0;
                end
            end else begin
                mPos++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] p, input logic [7:0] l);
        en = e;
        pat_sel = p;
        level = l;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic resetDut();
        rstn = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'd0);
        repeat (2) tick();
        rstn = 1'b1;
        modelReset();
    endtask

    typedef struct {
        logic [1:0]  pat;
        logic [7:0]  lvl;
        int          x;
        int          y;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[15];
    int   bad, found, period, hsRise, hsLen, vsRise, vsLen;

    // Watchdog so the bench always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'd0);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("reset_values", dutVec, RESET_VEC);

        // Idle with en low: reset-state stream held.
        resetDut();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (dutVec !== RESET_VEC) bad++;
        end
        checkOutput("idle_bad_cycles", bad, 0);
        checkOutput("idle_outputs", dutVec, RESET_VEC);

        // Pattern vectors at raster positions (x, y).
        vecs[0]  = '{2'd2, 8'h00, 0,  0, 24'hFFFFFF};
        vecs[1]  = '{2'd2, 8'h00, 2,  0, 24'hFFFF00};
        vecs[2]  = '{2'd2, 8'h00, 4,  0, 24'h00FFFF};
        vecs[3]  = '{2'd2, 8'h00, 14, 0, 24'h000000};
        vecs[4]  = '{2'd2, 8'h00, 6,  1, 24'h00FF00};
        vecs[5]  = '{2'd2, 8'h00, 9,  2, 24'hFF00FF};
        vecs[6]  = '{2'd2, 8'h00, 10, 3, 24'hFF0000};
        vecs[7]  = '{2'd2, 8'h00, 13, 0, 24'h0000FF};
        vecs[8]  = '{2'd0, 8'h80, 5,  1, 24'h808080};
        vecs[9]  = '{2'd0, 8'h3C, 20, 0, 24'h000000};
        vecs[10] = '{2'd1, 8'h00, 7,  2, 24'h070707};
        vecs[11] = '{2'd1, 8'h00, 15, 3, 24'h0F0F0F};
        vecs[12] = '{2'd1, 8'h00, 3,  5, 24'h000000};
        vecs[13] = '{2'd3, 8'hAA, 8,  1, 24'h000000};
        vecs[14] = '{2'd2, 8'h00, 15, 3, 24'h000000};
        for (int i = 0; i < 15; i++) begin
            resetDut();
            applyStimulus(1'b1, vecs[i].pat, vecs[i].lvl);
            repeat (2 + vecs[i].y * HT + vecs[i].x) tick();
            checkOutput($sformatf("vector%0d_rgb", i), {out_red, out_green, out_blue}, vecs[i].rgb);
        end

        // Raster timing: frame period, hsync and vsync placement.
        resetDut();
        applyStimulus(1'b1, 2'd0, 8'h10);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick();
            if (frame_start) found = 1;
        end
        checkOutput("first_frame_start", found, 1);
        period = -1; hsRise = -1; hsLen = 0; vsRise = -1; vsLen = 0;
        for (int c = 1; c < 400 && period < 0; c++) begin
            tick();
            if (out_hsync && hsRise < 0) hsRise = c;
            if (out_hsync && c < HT) hsLen++;
            if (out_vsync && vsRise < 0) vsRise = c;
            if (out_vsync) vsLen++;
            if (frame_start) period = c;
        end
        checkOutput("frame_period", period, FRAME);
        checkOutput("hsync_start", hsRise, HA + HFP);
        checkOutput("hsync_width", hsLen, HS);
        checkOutput("vsync_start", vsRise, (VA + VFP) * HT);
        checkOutput("vsync_width", vsLen, VS * HT);

        // Pattern change mid-frame applies only from the next frame.
        resetDut();
        applyStimulus(1'b1, 2'd0, 8'h80);
        repeat (2 + HT + 5) tick();
        checkOutput("midframe_before", {out_red, out_green, out_blue}, 24'h808080);
        applyStimulus(1'b1, 2'd1, 8'h80);
        repeat (HT) tick();
        checkOutput("midframe_after", {out_red, out_green, out_blue}, 24'h808080);
        repeat (FRAME - HT) tick();
        checkOutput("next_frame_ramp", {out_red, out_green, out_blue}, 24'h050505);

        // Dropping en on line 1 finishes the frame, then idles.
        resetDut();
        applyStimulus(1'b1, 2'd0, 8'h44);
        repeat (2 + HT) tick();
        applyStimulus(1'b0, 2'd0, 8'h44);
        repeat (180) tick();
        checkOutput("stop_frame_cnt", frame_cnt, 8'd1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!out_blank || frame_start || out_hsync || out_vsync) bad++;
        end
        checkOutput("stop_idle_bad_cycles", bad, 0);

        // Asynchronous reset mid-line.
        resetDut();
        applyStimulus(1'b1, 2'd0, 8'h55);
        repeat (2 + FRAME + 5) tick();
        checkOutput("pre_reset_state", dutVec, {24'h555555, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1});
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset", dutVec, RESET_VEC);
        tick();
        rstn = 1'b1;

        // Randomized run against the reference model.
        resetDut();
        en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 1) en = !en;
            pat_sel = 2'($urandom_range(0, 3));
            level = 8'($urandom_range(0, 255));
            tick();
            modelStep(en, pat_sel, level);
            checkOutput($sformatf("random_cycle%0d", i), dutVec, expVec);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
